// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock-enable divider.
// Divisor presets assume the 100 MHz board clock.
package clk_div_pkg;

    localparam int CLK_HZ        = 100_000_000;
    localparam int DIV_MIN       = 2;
    localparam int CNT_W_DEFAULT = 27;

    localparam int DIV_1HZ     = CLK_HZ;
    localparam int DIV_1KHZ    = CLK_HZ / 1_000;
    localparam int DIV_REFRESH = CLK_HZ / 200;

endpackage

// File: rtl/div_shadow_reg.sv
// Shadow register for the divisor: holds a pending value until the
// counter signals a safe point to switch, and rejects divisors below 2.
module div_shadow_reg
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_1HZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apply_i,
    input  logic             div_wr_i,
    input  logic [CNT_W-1:0] div_in_i,
    output logic             div_busy_o,
    output logic             div_err_o,
    output logic [CNT_W-1:0] div_cur_o
);

    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cur_q, cur_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             wr_ok;

    assign wr_ok = div_wr_i & (div_in_i >= CNT_W'(DIV_MIN));

    always_comb begin
        pend_d = pend_q;
        cur_d  = cur_q;
        busy_d = busy_q;
        err_d  = div_wr_i & ~wr_ok;
        if (apply_i) begin
            // A write landing on the switch point bypasses the shadow.
            if (wr_ok) begin
                cur_d  = div_in_i;
                busy_d = 1'b0;
            end else if (busy_q) begin
                cur_d  = pend_q;
                busy_d = 1'b0;
            end
        end else if (wr_ok) begin
            pend_d = div_in_i;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cur_q  <= CNT_W'(DEFAULT_DIV);
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cur_q  <= cur_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign div_busy_o = busy_q;
    assign div_err_o  = err_q;
    assign div_cur_o  = cur_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock-enable divider: tick pulse, square-wave
// enable and a wrapping tick counter, all synchronous to clk.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_1HZ,
    parameter int TC_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_in,
    output logic             div_busy,
    output logic             div_err,
    output logic [CNT_W-1:0] div_cur,
    output logic             tick,
    output logic             sq_out,
    output logic [TC_W-1:0]  tick_cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TC_W-1:0]  tcnt_q, tcnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             tc;
    logic             apply;

    // >= rather than == so a smaller divisor applied mid-pause still wraps.
    assign tc    = (cnt_q >= (div_cur - CNT_W'(1)));
    assign apply = clr | ~en | tc;

    div_shadow_reg #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .apply_i    (apply),
        .div_wr_i   (div_wr),
        .div_in_i   (div_in),
        .div_busy_o (div_busy),
        .div_err_o  (div_err),
        .div_cur_o  (div_cur)
    );

    always_comb begin
        cnt_d  = cnt_q;
        tcnt_d = tcnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (clr) begin
            cnt_d  = '0;
            tcnt_d = '0;
            sq_d   = 1'b0;
        end else if (en) begin
            cnt_d  = tc ? '0 : cnt_q + CNT_W'(1);
            tick_d = tc;
            tcnt_d = tcnt_q + TC_W'(tc);
            sq_d   = (cnt_d >= (div_cur >> 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tcnt_q <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tcnt_q <= tcnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick     = tick_q;
    assign sq_out   = sq_q;
    assign tick_cnt = tcnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog with DEFAULT_DIV=4, TC_W=4.
// Expected outputs are queued per driven cycle and popped after the edge.
module tb_clk_div_prog;

    localparam int CW = 27;
    localparam int TW = 4;
    localparam int OW = CW + TW + 4;

    typedef logic [OW-1:0] obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          div_wr = 1'b0;
    logic [CW-1:0] div_in = '0;
    logic          div_busy;
    logic          div_err;
    logic [CW-1:0] div_cur;
    logic          tick;
    logic          sq_out;
    logic [TW-1:0] tick_cnt;

    int   checks = 0;
    int   fails = 0;
    obs_t sb[$];
    obs_t e;

    int m_cnt, m_div, m_pend, m_tcnt;
    bit m_busy, m_tick, m_sq, m_err;

    clk_div_prog #(
        .CNT_W       (CW),
        .DEFAULT_DIV (4),
        .TC_W        (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .div_busy (div_busy),
        .div_err  (div_err),
        .div_cur  (div_cur),
        .tick     (tick),
        .sq_out   (sq_out),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t obs();
        return {tick, sq_out, tick_cnt, div_busy, div_err, div_cur};
    endfunction

    function automatic obs_t pack_exp();
        logic [TW-1:0] t;
        logic [CW-1:0] d;
        t = m_tcnt[TW-1:0];
        d = m_div[CW-1:0];
        return {m_tick, m_sq, t, m_busy, m_err, d};
    endfunction

    // Drive one cycle of stimulus, queue the reference result, wait the edge.
    task automatic step(input bit r, input bit en_v, input bit clr_v,
                        input bit wr_v, input int d);
        bit tcv, ap, vw;
        rst    = r;
        en     = en_v;
        clr    = clr_v;
        div_wr = wr_v;
        div_in = d[CW-1:0];
        if (r) begin
            m_cnt = 0; m_div = 4; m_pend = 0; m_tcnt = 0;
            m_busy = 0; m_tick = 0; m_sq = 0; m_err = 0;
        end else begin
            vw    = wr_v && (d >= 2);
            m_err = wr_v && (d < 2);
            tcv   = en_v && (m_cnt == m_div - 1);
            ap    = clr_v || !en_v || tcv;
            if (clr_v) begin
                m_cnt = 0; m_tick = 0; m_sq = 0; m_tcnt = 0;
            end else if (en_v) begin
                m_cnt  = tcv ? 0 : m_cnt + 1;
                m_tick = tcv;
                if (tcv) m_tcnt = (m_tcnt + 1) % (1 << TW);
                m_sq   = (m_cnt >= m_div / 2);
            end else begin
                m_tick = 0;
            end
            if (ap) begin
                if (vw) begin
                    m_div = d; m_busy = 0;
                end else if (m_busy) begin
                    m_div = m_pend; m_busy = 0;
                end
            end else if (vw) begin
                m_pend = d; m_busy = 1;
            end
        end
        sb.push_back(pack_exp());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tick !== 1'b0 || sq_out !== 1'b0 || tick_cnt !== '0) begin
            fails++;
            $display("FAIL reset_out got t=%b s=%b c=%0d exp 0/0/0",
                     tick, sq_out, tick_cnt);
        end
        checks++;
        if (div_cur !== 27'd4 || div_busy !== 1'b0 || div_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_div got cur=%0d busy=%b err=%b exp 4/0/0",
                     div_cur, div_busy, div_err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 1; i <= 13; i++) begin
            step(0, 1, 0, 0, 0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL basic_sb cyc=%0d got=%h exp=%h", i, obs(), e);
            end
            checks++;
            if (tick !== (i % 4 == 0) || sq_out !== ((i % 4) >= 2)) begin
                fails++;
                $display("FAIL basic_wave cyc=%0d got t=%b s=%b exp t=%b s=%b",
                         i, tick, sq_out, i % 4 == 0, (i % 4) >= 2);
            end
        end
        checks++;
        if (tick_cnt !== 4'd3) begin
            fails++;
            $display("FAIL basic_tcnt got=%0d exp=3", tick_cnt);
        end
    endtask

    task automatic test_div_change();
        bit et, es;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, i == 2, 6);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL chg_sb cyc=%0d got=%h exp=%h", i, obs(), e);
            end
            et = (i == 4 || i == 10 || i == 16);
            es = (i < 4) ? ((i % 4) >= 2) : (((i - 4) % 6) >= 3);
            checks++;
            if (tick !== et || sq_out !== es) begin
                fails++;
                $display("FAIL chg_wave cyc=%0d got t=%b s=%b exp t=%b s=%b",
                         i, tick, sq_out, et, es);
            end
            if (i == 2) begin
                checks++;
                if (div_busy !== 1'b1 || div_cur !== 27'd4) begin
                    fails++;
                    $display("FAIL chg_pend got busy=%b cur=%0d exp 1/4",
                             div_busy, div_cur);
                end
            end
            if (i == 4) begin
                checks++;
                if (div_busy !== 1'b0 || div_cur !== 27'd6) begin
                    fails++;
                    $display("FAIL chg_apply got busy=%b cur=%0d exp 0/6",
                             div_busy, div_cur);
                end
            end
        end
    endtask

    task automatic test_div_err();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, i == 2 || i == 4, (i == 2) ? 1 : 0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL err_sb cyc=%0d got=%h exp=%h", i, obs(), e);
            end
            checks++;
            if (div_err !== (i == 2 || i == 4) || div_cur !== 27'd4 ||
                div_busy !== 1'b0) begin
                fails++;
                $display("FAIL err_pulse cyc=%0d got err=%b cur=%0d busy=%b",
                         i, div_err, div_cur, div_busy);
            end
        end
    endtask

    task automatic test_pause();
        bit pen;
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            pen = !((i >= 7 && i <= 16) || i == 19);
            step(0, pen, 0, i == 19, 5);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL pause_sb cyc=%0d got=%h exp=%h", i, obs(), e);
            end
            checks++;
            if (tick !== (i == 4 || i == 18 || i == 24)) begin
                fails++;
                $display("FAIL pause_tick cyc=%0d got=%b", i, tick);
            end
            if (i >= 7 && i <= 16) begin
                checks++;
                if (sq_out !== 1'b1 || tick_cnt !== 4'd1) begin
                    fails++;
                    $display("FAIL pause_hold cyc=%0d got s=%b c=%0d exp 1/1",
                             i, sq_out, tick_cnt);
                end
            end
            if (i == 19) begin
                checks++;
                if (div_cur !== 27'd5 || div_busy !== 1'b0) begin
                    fails++;
                    $display("FAIL pause_wr got cur=%0d busy=%b exp 5/0",
                             div_cur, div_busy);
                end
            end
        end
        checks++;
        if (tick_cnt !== 4'd3) begin
            fails++;
            $display("FAIL pause_tcnt got=%0d exp=3", tick_cnt);
        end
    endtask

    task automatic test_clr();
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            step(0, 1, i == 8, i == 6, 7);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL clr_sb cyc=%0d got=%h exp=%h", i, obs(), e);
            end
            checks++;
            if (tick !== (i == 4 || i == 15)) begin
                fails++;
                $display("FAIL clr_tick cyc=%0d got=%b", i, tick);
            end
            if (i == 6) begin
                checks++;
                if (div_busy !== 1'b1 || div_cur !== 27'd4) begin
                    fails++;
                    $display("FAIL clr_pend got busy=%b cur=%0d exp 1/4",
                             div_busy, div_cur);
                end
            end
            if (i == 8) begin
                checks++;
                if (tick_cnt !== 4'd0 || div_cur !== 27'd7 ||
                    div_busy !== 1'b0 || sq_out !== 1'b0) begin
                    fails++;
                    $display("FAIL clr_state got c=%0d cur=%0d busy=%b s=%b",
                             tick_cnt, div_cur, div_busy, sq_out);
                end
            end
        end
        checks++;
        if (tick_cnt !== 4'd1) begin
            fails++;
            $display("FAIL clr_tcnt got=%0d exp=1", tick_cnt);
        end
    endtask

    task automatic test_rst_mid_and_wrap();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(i == 3, 1, 0, i == 2, 9);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL rst_sb cyc=%0d got=%h exp=%h", i, obs(), e);
            end
        end
        checks++;
        if (div_cur !== 27'd4 || div_busy !== 1'b0 || tick !== 1'b0 ||
            sq_out !== 1'b0 || tick_cnt !== 4'd0) begin
            fails++;
            $display("FAIL rst_mid got cur=%0d busy=%b t=%b s=%b c=%0d",
                     div_cur, div_busy, tick, sq_out, tick_cnt);
        end
        for (int i = 1; i <= 64; i++) begin
            step(0, 1, 0, 0, 0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL wrap_sb cyc=%0d got=%h exp=%h", i, obs(), e);
            end
            if (i == 60) begin
                checks++;
                if (tick_cnt !== 4'd15) begin
                    fails++;
                    $display("FAIL wrap_15 got=%0d exp=15", tick_cnt);
                end
            end
        end
        checks++;
        if (tick_cnt !== 4'd0 || tick !== 1'b1) begin
            fails++;
            $display("FAIL wrap_0 got c=%0d t=%b exp 0/1", tick_cnt, tick);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_change();
        test_div_err();
        test_pause();
        test_clr();
        test_rst_mid_and_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
